// File: rtl/seq_pkg.sv
// Shared types and defaults for the step-sequencer playback controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package seq_pkg;

  localparam int STEPS_DEF   = 8;
  localparam int VOICES_DEF  = 8;
  localparam int TEMPO_W_DEF = 24;

  // Shortest step the FETCH/CAPTURE/RUN pipeline can sustain, in clk cycles.
  localparam int MIN_PERIOD  = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    CAPTURE = 2'd2,
    RUN     = 2'd3
  } state_t;

endpackage

// File: rtl/seq_step_timer.sv
// Loadable saturating down-counter; expired is high while the count sits at 0.
// Latency: load takes effect on the next clk edge; expired is combinational from the count.
// Backpressure: none; dec is ignored once the count reaches 0.
module seq_step_timer #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         expired
);

  logic [W-1:0] count;

  // Load has priority over decrement; the count never wraps below zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/seq_play_ctrl.sv
// Step-sequencer playback: tempo, looping playhead, pattern row fetch, voice gates (swing via SEQ_SWING_EN).
// Latency: start to first step_strobe is 3 cycles; strobes then repeat every step duration.
// Backpressure: none; the pattern port must return rd_data the cycle after rd_en.
module seq_play_ctrl
  import seq_pkg::*;
#(
  parameter  int STEPS   = STEPS_DEF,
  parameter  int VOICES  = VOICES_DEF,
  parameter  int TEMPO_W = TEMPO_W_DEF,
  localparam int SW      = $clog2(STEPS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [TEMPO_W-1:0] tempo_div,
  input  logic [TEMPO_W-1:0] gate_len,
  input  logic [SW-1:0]      loop_last,
  output logic               rd_en,
  output logic [SW-1:0]      rd_addr,
  input  logic [VOICES-1:0]  rd_data,
  output logic [VOICES-1:0]  voice_gate,
  output logic               step_strobe,
  output logic [SW-1:0]      step_idx,
  output logic               playing
`ifdef SEQ_SWING_EN
  ,
  input  logic [TEMPO_W-2:0] swing_amt
`endif
);

  state_t             state;
  logic [SW-1:0]      loop_last_q;
  logic [TEMPO_W-1:0] t_eff;
  logic [TEMPO_W-1:0] t_minus_min;
  logic [TEMPO_W-1:0] step_load;
  logic [TEMPO_W-1:0] gate_load;
  logic [SW-1:0]      next_idx;
  logic               tmr_load;
  logic               step_dec;
  logic               gate_dec;
  logic               step_expired;
  logic               gate_expired;

  // Effective period T; the pipeline needs at least MIN_PERIOD cycles per step.
  assign t_eff       = (tempo_div < TEMPO_W'(MIN_PERIOD)) ? TEMPO_W'(MIN_PERIOD) : tempo_div;
  assign t_minus_min = t_eff - TEMPO_W'(MIN_PERIOD);

  // The step timer counts RUN cycles after the strobe cycle: a step of D cycles
  // spends D-2 cycles in RUN, so it is loaded with D-3 and leaves RUN at zero.
`ifdef SEQ_SWING_EN
  logic [TEMPO_W-1:0] swing_ext;
  logic [TEMPO_W-1:0] s_eff;
  logic [TEMPO_W:0]   long_load;

  // S is clamped to T-3 so the short (odd) step never drops below MIN_PERIOD.
  assign swing_ext = {1'b0, swing_amt};
  assign s_eff     = (swing_ext > t_minus_min) ? t_minus_min : swing_ext;
  assign long_load = {1'b0, t_minus_min} + {1'b0, s_eff};
  assign step_load = step_idx[0] ? (t_minus_min - s_eff)
                                 : (long_load[TEMPO_W] ? '1 : long_load[TEMPO_W-1:0]);
`else
  assign step_load = t_minus_min;
`endif

  // Gate timer counts from the strobe cycle; zero means this cycle is the last gated one.
  assign gate_load = (gate_len == '0) ? '0 : (gate_len - TEMPO_W'(1));

  // Both step_idx == loop_last and an out-of-range playhead wrap to step 0.
  assign next_idx = (step_idx >= loop_last_q) ? '0 : (step_idx + SW'(1));

  assign tmr_load = (state == CAPTURE);
  assign step_dec = (state == RUN);
  // The gate timer keeps running through FETCH/CAPTURE so gates shorter than
  // the step can still end there; the next CAPTURE overrides it anyway.
  assign gate_dec = (state != IDLE);

  seq_step_timer #(.W(TEMPO_W)) u_step_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (step_load),
    .dec      (step_dec),
    .expired  (step_expired)
  );

  seq_step_timer #(.W(TEMPO_W)) u_gate_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (gate_load),
    .dec      (gate_dec),
    .expired  (gate_expired)
  );

  // Playback FSM with registered outputs; stop beats start, start beats normal sequencing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      rd_en       <= 1'b0;
      rd_addr     <= '0;
      voice_gate  <= '0;
      step_strobe <= 1'b0;
      step_idx    <= '0;
      playing     <= 1'b0;
      loop_last_q <= '0;
    end else begin
      rd_en       <= 1'b0;
      step_strobe <= 1'b0;
      if (stop) begin
        state      <= IDLE;
        voice_gate <= '0;
        step_idx   <= '0;
        rd_addr    <= '0;
        playing    <= 1'b0;
      end else if (start) begin
        // Restart cleanly: the old row must not keep sounding into step 0.
        state      <= FETCH;
        rd_en      <= 1'b1;
        rd_addr    <= '0;
        step_idx   <= '0;
        voice_gate <= '0;
        playing    <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            voice_gate <= '0;
          end
          FETCH: begin
            state <= CAPTURE;
            if (gate_expired) voice_gate <= '0;
          end
          CAPTURE: begin
            // Row, gate length and loop bound are all taken here, once per step.
            state       <= RUN;
            voice_gate  <= (gate_len != '0) ? rd_data : '0;
            step_strobe <= 1'b1;
            loop_last_q <= loop_last;
          end
          RUN: begin
            if (gate_expired) voice_gate <= '0;
            if (step_expired) begin
              state    <= FETCH;
              rd_en    <= 1'b1;
              rd_addr  <= next_idx;
              step_idx <= next_idx;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seq_play_ctrl.sv
// Directed bench for seq_play_ctrl with a strobe scoreboard (swing cases need SEQ_SWING_EN).
// Latency: expected strobes are queued when start is driven and checked as they appear.
// Backpressure: n/a; the pattern memory model answers every rd_en one cycle later.
module tb_seq_play_ctrl;

  localparam int TW = 24;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          stop;
  logic [TW-1:0] tempo_div;
  logic [TW-1:0] gate_len;
  logic [2:0]    loop_last;
  logic          rd_en;
  logic [2:0]    rd_addr;
  logic [7:0]    rd_data = 8'h00;
  logic [7:0]    voice_gate;
  logic          step_strobe;
  logic [2:0]    step_idx;
  logic          playing;
`ifdef SEQ_SWING_EN
  logic [TW-2:0] swing_amt;
`endif

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pattern store: rows answer one cycle after rd_en, garbage otherwise.
  logic [7:0] mem [8];
  always @(posedge clk) rd_data <= rd_en ? mem[rd_addr] : 8'hA5;

  seq_play_ctrl #(.STEPS(8), .VOICES(8), .TEMPO_W(TW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .tempo_div   (tempo_div),
    .gate_len    (gate_len),
    .loop_last   (loop_last),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .voice_gate  (voice_gate),
    .step_strobe (step_strobe),
    .step_idx    (step_idx),
    .playing     (playing)
`ifdef SEQ_SWING_EN
    ,
    .swing_amt   (swing_amt)
`endif
  );

  typedef struct {
    logic [2:0] idx;
    logic [7:0] gate;
    int         gap;
    int         hi;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;
  int   ref_cyc = 0;
  int   epoch   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Queue n expected strobes; d_even/d_odd are step durations by index parity.
  task automatic push_steps(input int first_idx, input int n, input int first_gap,
                            input int d_even, input int d_odd, input int glen, input int last);
    int idx;
    int prev_dur;
    idx      = first_idx;
    prev_dur = 0;
    for (int i = 0; i < n; i++) begin
      exp_t e;
      int   dur;
      dur    = (idx % 2 == 0) ? d_even : d_odd;
      e.idx  = idx[2:0];
      e.gate = (glen == 0) ? 8'h00 : mem[idx[2:0]];
      e.gap  = (i == 0) ? first_gap : prev_dur;
      e.hi   = (glen == 0) ? 0 : ((glen < dur) ? glen : dur);
      sb.push_back(e);
      prev_dur = dur;
      idx      = (idx >= last) ? 0 : idx + 1;
    end
  endtask

  task automatic start_run();
    epoch++;
    ref_cyc = cyc;
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  task automatic drain(input string tag, input int budget);
    int k;
    k = 0;
    while (sb.size() != 0 && k < budget) begin
      tick();
      k++;
    end
    chk(tag, 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  task automatic stop_run();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    epoch++;
    chk("stop_playing", 32'(playing), 32'd0);
    chk("stop_gate", 32'(voice_gate), 32'd0);
    chk("stop_idx", 32'(step_idx), 32'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rd_en"}, 32'(rd_en), 32'd0);
    chk({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
    chk({tag, "_gate"}, 32'(voice_gate), 32'd0);
    chk({tag, "_strobe"}, 32'(step_strobe), 32'd0);
    chk({tag, "_idx"}, 32'(step_idx), 32'd0);
    chk({tag, "_playing"}, 32'(playing), 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    stop      = 1'b0;
    tempo_div = TW'(10);
    gate_len  = TW'(4);
    loop_last = 3'd7;
`ifdef SEQ_SWING_EN
    swing_amt = '0;
`endif
    for (int i = 0; i < 8; i++) mem[i] = 8'h01 << i;

    // Strobe monitor: pops the scoreboard on every step_strobe.
    fork
      begin : mon
        int         seen_epoch;
        int         last_cyc;
        int         hi_cnt;
        int         prev_hi;
        bit         prev_valid;
        logic       en_d1, en_d2;
        logic [2:0] ad_d1, ad_d2;
        exp_t       e;
        seen_epoch = 0; last_cyc = 0; hi_cnt = 0; prev_hi = 0; prev_valid = 1'b0;
        en_d1 = 1'b0; en_d2 = 1'b0; ad_d1 = '0; ad_d2 = '0;
        forever begin
          @(negedge clk);
          if (seen_epoch != epoch) begin
            seen_epoch = epoch;
            last_cyc   = ref_cyc;
            prev_valid = 1'b0;
          end
          if (step_strobe === 1'b1) begin
            if (sb.size() == 0) begin
              chk("unexpected_strobe", 32'(step_strobe), 32'd0);
            end else begin
              e = sb.pop_front();
              chk("strobe_idx", 32'(step_idx), 32'(e.idx));
              chk("strobe_gate", 32'(voice_gate), 32'(e.gate));
              chk("strobe_gap", 32'(cyc - last_cyc), 32'(e.gap));
              chk("fetch_rd_en", 32'(en_d2), 32'd1);
              chk("fetch_addr", 32'(ad_d2), 32'(e.idx));
              chk("rd_en_single", 32'(en_d1), 32'd0);
              if (prev_valid) chk("gate_hi_cycles", 32'(hi_cnt), 32'(prev_hi));
              prev_valid = 1'b1;
              prev_hi    = e.hi;
            end
            last_cyc = cyc;
            hi_cnt   = (voice_gate != 8'h00) ? 1 : 0;
          end else if (voice_gate != 8'h00) begin
            hi_cnt++;
          end
          en_d2 = en_d1; en_d1 = rd_en;
          ad_d2 = ad_d1; ad_d1 = rd_addr;
        end
      end
    join_none

    // Reset values while rst is held.
    repeat (3) tick();
    chk_reset_vals("reset");
    rst = 1'b0;
    tick();

    // Basic loop: T=10, 4-cycle gates, full 8-step loop wrapping 7->0.
    push_steps(0, 10, 3, 10, 10, 4, 7);
    start_run();
    chk("start_playing", 32'(playing), 32'd1);
    chk("start_rd_en", 32'(rd_en), 32'd1);
    chk("start_rd_addr", 32'(rd_addr), 32'd0);
    drain("basic_drain", 200);
    stop_run();
    repeat (3) tick();

    // Short loop at minimum period: tempo_div=1 acts as T=3, gates clamp to 3.
    loop_last = 3'd2;
    tempo_div = TW'(1);
    push_steps(0, 7, 3, 3, 3, 4, 2);
    start_run();
    drain("short_drain", 100);
    stop_run();
    repeat (3) tick();

    // gate_len=0: strobes keep coming, gates never open.
    loop_last = 3'd7;
    tempo_div = TW'(10);
    gate_len  = TW'(0);
    push_steps(0, 3, 3, 10, 10, 0, 7);
    start_run();
    drain("gate0_drain", 100);
    stop_run();
    repeat (3) tick();

    // gate_len > T: gates continuous, replaced only at strobes.
    gate_len = TW'(50);
    push_steps(0, 4, 3, 10, 10, 50, 7);
    start_run();
    drain("gatelong_drain", 100);
    stop_run();
    repeat (3) tick();

    // stop during CAPTURE: the fetched row must never reach the gates.
    gate_len = TW'(4);
    start_run();
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("capstop_gate", 32'(voice_gate), 32'd0);
    chk("capstop_playing", 32'(playing), 32'd0);
    chk("capstop_strobe", 32'(step_strobe), 32'd0);
    repeat (12) tick();
    chk("capstop_idle", 32'(playing), 32'd0);

    // start and stop together while playing: stop wins.
    push_steps(0, 2, 3, 10, 10, 4, 7);
    start_run();
    drain("collide_drain", 60);
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    epoch++;
    chk("collide_playing", 32'(playing), 32'd0);
    chk("collide_rd_en", 32'(rd_en), 32'd0);
    repeat (15) tick();
    chk("collide_idle", 32'(playing), 32'd0);

    // start while playing at step 5: next strobe is step 0 after 3 cycles.
    push_steps(0, 6, 3, 10, 10, 4, 7);
    start_run();
    drain("pre_restart_drain", 100);
    push_steps(0, 3, 3, 10, 10, 4, 7);
    start_run();
    chk("restart_idx", 32'(step_idx), 32'd0);
    chk("restart_rd_en", 32'(rd_en), 32'd1);
    drain("restart_drain", 100);
    stop_run();
    repeat (3) tick();

    // Asynchronous reset between clock edges mid-RUN.
    push_steps(0, 3, 3, 10, 10, 4, 7);
    start_run();
    drain("prereset_drain", 100);
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk_reset_vals("async_rst");
    tick();
    rst = 1'b0;
    tick();
    push_steps(0, 2, 3, 10, 10, 4, 7);
    start_run();
    drain("postreset_drain", 60);
    stop_run();
    repeat (3) tick();

`ifdef SEQ_SWING_EN
    // Swing S=3 on T=10: even steps 13 cycles, odd steps 7.
    swing_amt = (TW-1)'(3);
    push_steps(0, 5, 3, 13, 7, 4, 7);
    start_run();
    drain("swing3_drain", 120);
    stop_run();
    repeat (3) tick();

    // Swing 20 clamps to S=7: 17 / 3, odd-step gates clamp to 3.
    swing_amt = (TW-1)'(20);
    push_steps(0, 5, 3, 17, 3, 4, 7);
    start_run();
    drain("swing20_drain", 120);
    stop_run();
    repeat (3) tick();
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
